// File: rtl/task_scheduler.sv
// Round-robin grant arbiter for the shared analyser datapath.
// One engine at a time, one idle cycle between tenures, watchdog reclaim.
module task_scheduler #(
    parameter int N_TASKS  = 4,
    parameter int TO_WIDTH = 16,
    parameter int IDX_W    = $clog2(N_TASKS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_TASKS-1:0]  task_en,
    input  logic [N_TASKS-1:0]  done,
    input  logic [TO_WIDTH-1:0] timeout_limit,
    output logic [N_TASKS-1:0]  grant,
    output logic [IDX_W-1:0]    active_idx,
    output logic                idle,
    output logic                timeout_pulse,
    output logic [IDX_W-1:0]    timeout_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_GAP
    } state_t;

    state_t state;
    state_t state_n;

    logic [IDX_W-1:0]    last;
    logic [IDX_W-1:0]    last_n;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    cand;
    logic [TO_WIDTH-1:0] cnt;
    logic [TO_WIDTH-1:0] cnt_n;
    logic [N_TASKS-1:0]  grant_n;
    logic [IDX_W-1:0]    active_n;
    logic [IDX_W-1:0]    tidx_n;
    logic                pulse_n;
    logic                any_en;
    logic                revoke;
    logic                fin;
    logic                wd_fire;

    // Scan downward so the nearest enabled index after last wins.
    always_comb begin
        sel_idx = last;
        cand    = last;
        for (int k = N_TASKS; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % N_TASKS);
            if (task_en[cand]) begin
                sel_idx = cand;
            end
        end
    end

    assign any_en = |task_en;
    assign revoke = !task_en[active_idx];
    assign fin    = done[active_idx];

    always_comb begin
        wd_fire = 1'b0;
        if (state == S_GRANT
            && timeout_limit != '0
            && cnt == timeout_limit - TO_WIDTH'(1)
            && !revoke && !fin) begin
            wd_fire = 1'b1;
        end
    end

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        active_n = active_idx;
        last_n   = last;
        cnt_n    = cnt;
        pulse_n  = 1'b0;
        tidx_n   = timeout_idx;
        unique case (state)
            S_IDLE, S_GAP: begin
                if (any_en) begin
                    state_n  = S_GRANT;
                    grant_n  = N_TASKS'(1) << sel_idx;
                    active_n = sel_idx;
                    last_n   = sel_idx;
                    cnt_n    = '0;
                end else begin
                    state_n = S_IDLE;
                    grant_n = '0;
                end
            end
            S_GRANT: begin
                if (revoke || fin || wd_fire) begin
                    state_n = S_GAP;
                    grant_n = '0;
                    pulse_n = wd_fire;
                    if (wd_fire) begin
                        tidx_n = active_idx;
                    end
                end else if (cnt != '1) begin
                    cnt_n = cnt + TO_WIDTH'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            grant         <= '0;
            active_idx    <= '0;
            idle          <= 1'b1;
            timeout_pulse <= 1'b0;
            timeout_idx   <= '0;
            last          <= IDX_W'(N_TASKS - 1);
            cnt           <= '0;
        end else begin
            state         <= state_n;
            grant         <= grant_n;
            active_idx    <= active_n;
            idle          <= (state_n != S_GRANT);
            timeout_pulse <= pulse_n;
            timeout_idx   <= tidx_n;
            last          <= last_n;
            cnt           <= cnt_n;
        end
    end

endmodule

// File: tb/tb_task_scheduler.sv
// Bench for task_scheduler: directed scenarios plus random traffic
// checked against a tenure-level reference model.
module tb_task_scheduler;

    localparam int N  = 4;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  task_en;
    logic [N-1:0]  done;
    logic [TW-1:0] timeout_limit;
    logic [N-1:0]  grant;
    logic [1:0]    active_idx;
    logic          idle;
    logic          timeout_pulse;
    logic [1:0]    timeout_idx;

    task_scheduler #(
        .N_TASKS (N),
        .TO_WIDTH(TW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .task_en      (task_en),
        .done         (done),
        .timeout_limit(timeout_limit),
        .grant        (grant),
        .active_idx   (active_idx),
        .idle         (idle),
        .timeout_pulse(timeout_pulse),
        .timeout_idx  (timeout_idx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: owner is -1 whenever nobody holds the datapath.
    int m_owner;
    int m_last;
    int m_aidx;
    int m_tidx;
    int m_ten;
    bit m_pulse;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_aidx  = 0;
        m_tidx  = 0;
        m_ten   = 0;
        m_pulse = 0;
    endfunction

    function automatic int pick_next();
        int p = -1;
        for (int k = 1; k <= N; k++) begin
            int j = (m_last + k) % N;
            if (p < 0 && task_en[j]) p = j;
        end
        return p;
    endfunction

    function automatic void model_edge();
        m_pulse = 0;
        if (m_owner >= 0) begin
            bit rv = !task_en[m_owner];
            bit dn = done[m_owner];
            bit wd = (timeout_limit != 0) && (m_ten == int'(timeout_limit))
                     && !rv && !dn;
            if (rv || dn || wd) begin
                if (wd) m_tidx = m_owner;
                m_pulse = wd;
                m_owner = -1;
            end else begin
                m_ten++;
            end
        end else begin
            int p = pick_next();
            if (p >= 0) begin
                m_owner = p;
                m_last  = p;
                m_aidx  = p;
                m_ten   = 1;
            end
        end
    endfunction

    task automatic check_all();
        chk("grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("active_idx", active_idx, m_aidx);
        chk("idle", idle, (m_owner < 0) ? 1 : 0);
        chk("timeout_pulse", timeout_pulse, m_pulse);
        chk("timeout_idx", timeout_idx, m_tidx);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int cnt;
        rst           = 1'b1;
        task_en       = '0;
        done          = '0;
        timeout_limit = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Full rotation with done from each grantee
        task_en = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("t1_grant", grant, 32'd1 << (k % 4));
            done = grant;
            step();
            chk("t1_gap", grant, 0);
            chk("t1_gap_idle", idle, 1);
            done = '0;
            step();
        end

        // Masked engines never granted, then revoke to IDLE
        task_en = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            chk("t2_mask", grant & 4'b0101, 0);
            chk("t2_nz", grant != 0, 1);
            done = grant;
            step();
            done = '0;
            step();
        end
        task_en = '0;
        repeat (4) step();
        chk("t2_idle", grant, 0);

        // Watchdog reclaim after 5 cycles
        timeout_limit = 16'd5;
        task_en       = 4'b0011;
        step();
        chk("t3_first", grant, 1);
        cnt = 0;
        while (grant[0] && cnt < 50) begin
            cnt++;
            step();
        end
        chk("t3_len", cnt, 5);
        chk("t3_pulse", timeout_pulse, 1);
        chk("t3_tidx", timeout_idx, 0);
        step();
        chk("t3_next", grant, 4'b0010);

        // Foreign done ignored; done wins over same-cycle expiry
        done = 4'b1101;
        repeat (4) step();
        chk("t4_hold", grant, 4'b0010);
        done = 4'b0010;
        step();
        chk("t4_nopulse", timeout_pulse, 0);
        chk("t4_gap", idle, 1);
        done = '0;

        // Sole enabled engine re-granted
        timeout_limit = '0;
        task_en       = 4'b0100;
        step();
        for (int k = 0; k < 3; k++) begin
            chk("t5_grant", grant, 4'b0100);
            chk("t5_idx", active_idx, 2);
            done = 4'b0100;
            step();
            chk("t5_gap", grant, 0);
            done = '0;
            step();
        end

        // Asynchronous reset mid-tenure
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async", grant, 0);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst     = 1'b0;
        task_en = 4'b0110;
        step();
        chk("t6_first", grant, 4'b0010);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) task_en = N'($urandom);
            done = N'($urandom & $urandom);
            if (m_owner < 0 && $urandom_range(9) == 0)
                timeout_limit = TW'($urandom_range(0, 8));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/task_scheduler.md
# task_scheduler

Parametrised round-robin scheduler that time-multiplexes the analyser's shared datapath between `N_TASKS` engines (acquisition, transmit, trigger-config, self-test, …). It grants exactly one enabled engine at a time, hands over on that engine's `done` pulse, skips engines whose enable is low, and forcibly reclaims a grant after a programmable watchdog timeout. It sits between the top-level control registers and the engine grant/done pins. It generalises the two-engine acquire/transmit dispatcher to N engines with enable masking and timeout.

## Interface
- `N_TASKS`, default 4, number of engines; legal range 2..16.
- `TO_WIDTH`, default 16, width of the watchdog counter and limit.
- `IDX_W`, default `$clog2(N_TASKS)`, width of the index outputs; derived, do not override.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `task_en`  in  N_TASKS  per-engine participation mask; sampled every cycle.
- `done`  in  N_TASKS  per-engine completion; only the bit of the granted engine is honoured.
- `timeout_limit`  in  TO_WIDTH  watchdog limit in cycles; 0 disables the watchdog.
- `grant`  out  N_TASKS  one-hot or zero; registered.
- `active_idx`  out  IDX_W  index of the granted engine; holds the last value while no engine is granted.
- `idle`  out  1  high when no engine is granted, i.e. in the IDLE or GAP state.
- `timeout_pulse`  out  1  one-cycle strobe when the watchdog reclaims a grant.
- `timeout_idx`  out  IDX_W  index of the engine that last timed out; sticky until the next timeout.

## Operation
- States:
  - IDLE: no engine enabled.
  - GRANT: one engine owns the datapath.
  - GAP: exactly one cycle with `grant` all-zero between tenures.
- Round-robin pointer `last` holds the index of the most recently granted engine; reset value is N_TASKS-1.
- Selection: the first index `i` with `task_en[i]=1`, searching `last+1, last+2, …` with wrap modulo N_TASKS. `last` itself is the final candidate, so a sole enabled engine is re-granted.
- IDLE → GRANT when any `task_en` bit is 1. The selected engine is granted and `last` is updated to it.
- GRANT → GAP on the first of these (priority order):
  - (a) `task_en[active_idx]` falls, which revokes the grant silently.
  - (b) `done[active_idx]`=1.
  - (c) the watchdog fires.
- Watchdog:
  - The counter clears on entry to GRANT and increments each GRANT cycle, saturating at all-ones.
  - It fires when `timeout_limit`≠0, counter == `timeout_limit`-1, and neither (a) nor (b) holds in the same cycle.
  - The tenure is therefore limited to exactly `timeout_limit` cycles.
- GAP → GRANT if any `task_en` bit is 1 (selection as above); otherwise GAP → IDLE.
- `done` bits of non-granted engines, and any `done` seen in IDLE or GAP, are ignored. No done is latched or queued.
- A change to `timeout_limit` mid-tenure takes effect immediately, compared against the live counter. If the counter is already ≥ limit-1, the watchdog fires next cycle only if counter == limit-1; otherwise it fires only on saturation wrap, which does not occur. Software must change the limit only while `idle`=1.
- Reset values: state=IDLE, `grant`=0, `active_idx`=0, `idle`=1, `timeout_pulse`=0, `timeout_idx`=0, `last`=N_TASKS-1, counter=0.
- Asynchronous reset mid-tenure drops `grant` immediately, with no GAP.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Handover: `done` high in the cycle ending at edge t. From edge t, `grant`=0 and `idle`=1 (GAP). From edge t+1, the next engine's `grant` is high. Engine-to-engine latency is 2 edges.
- Start: `task_en` goes nonzero before edge t in IDLE; `grant` is high from edge t.
- `timeout_pulse` is asserted in the same cycle as GAP entry caused by the watchdog. `timeout_idx` updates at that same edge.
- `active_idx` updates at the same edge `grant` asserts.
- A `done` held high for several cycles ends only one tenure. On a re-grant of the same engine, `done` is re-sampled from the new GRANT cycle onward, so engines must drop `done` within the GAP cycle.

## Test plan
- Reset then `task_en`=4'b1111 with `done` pulsed by each grantee: grant sequence 0001→0010→0100→1000→0001, a single zero cycle between each, `idle`=1 only in those gaps.
- `task_en`=4'b1010, `done` pulsed per tenure: grants alternate 0010/1000 and indices 0 and 2 are never granted. Then set `task_en`=0: state reaches IDLE after the current tenure ends by revocation, and `grant` stays 0.
- `timeout_limit`=5 with engine 0 never asserting `done`: `grant[0]` is high for exactly 5 cycles, `timeout_pulse` is high 1 cycle at the GAP, `timeout_idx`=0, and the next grant goes to engine 1.
- `done[active]` and the watchdog expiry in the same cycle: `timeout_pulse` stays 0 and a normal handover occurs. `done` on a non-granted engine: no effect.
- Single enabled engine (`task_en`=4'b0100) pulsing `done`: `grant` follows 0100, 0000 for 1 cycle, 0100 again, and `active_idx` stays 2.
- Assert `rst` asynchronously mid-tenure: `grant`=0 before the next clock edge. After release, the first grant goes to the lowest enabled index.
